// File: rtl/bus_pkg.sv
// Shared definitions for the req/cmd/addr/wdata/ack/rdata bus.
//   ADDR_W / DATA_W       : bus field widths
//   CMD_READ / CMD_WRITE  : encoding of the one-bit command field
//   arb_state_t           : arbiter FSM states
package bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req  : request vector, one bit per requester
//   last : index of the most recently granted requester
//   gnt  : one-hot grant for the first set request above last (wrapping)
//   idx  : binary index of that grant
//   vld  : at least one request is set
module rr_picker #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  always_comb begin
    int          cand;
    logic [IW-1:0] cidx;
    gnt  = '0;
    idx  = '0;
    vld  = 1'b0;
    cand = 0;
    cidx = '0;
    // Offset 1 first so the last winner is considered only after everyone else.
    for (int off = 1; off <= N; off++) begin
      cand = int'(last) + off;
      if (cand >= N) cand = cand - N;
      cidx = IW'(cand);
      if (!vld && req[cidx]) begin
        vld       = 1'b1;
        gnt[cidx] = 1'b1;
        idx       = cidx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one slave port among NUM_MASTERS masters.
//   clk, rst_n               : clock, synchronous active-low reset
//   m_req/m_cmd/m_addr/m_wdata : per-master command fields (addr/wdata packed, master i at [32i+31:32i])
//   m_ack, m_rdata           : per-master ack pulse, broadcast read data
//   s_req/s_cmd/s_addr/s_wdata : command muxed to the slave
//   s_ack, s_rdata           : slave acknowledge and read data
//   gnt, busy, timeout_err   : registered grant, busy flag, watchdog release pulse
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_cmd,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_req,
  output logic                          s_cmd,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic                          s_ack,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic [NUM_MASTERS-1:0]        gnt,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int              IW      = $clog2(NUM_MASTERS);
  localparam int              WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_MAX  = '1;

  arb_state_t             state, state_nxt;
  logic [NUM_MASTERS-1:0] gnt_nxt;
  logic [IW-1:0]          last_gnt, last_gnt_nxt;
  logic [WD_W-1:0]        wdog, wdog_nxt;
  logic                   terr_nxt;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IW-1:0]          pick_idx;
  logic                   pick_vld;

  rr_picker #(
    .N (NUM_MASTERS)
  ) u_picker (
    .req  (m_req),
    .last (last_gnt),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= '0;
      last_gnt    <= IW'(NUM_MASTERS - 1);
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      gnt         <= gnt_nxt;
      last_gnt    <= last_gnt_nxt;
      wdog        <= wdog_nxt;
      timeout_err <= terr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    last_gnt_nxt = last_gnt;
    wdog_nxt     = wdog;
    terr_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt    = BUSY;
          gnt_nxt      = pick_gnt;
          last_gnt_nxt = pick_idx;
          wdog_nxt     = '0;
        end
      end
      BUSY: begin
        // Priority order makes an ack on the final watchdog cycle win over the timeout.
        if (s_ack) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end else if (~|(m_req & gnt)) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end else if (wdog == WD_LAST) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          terr_nxt  = 1'b1;
        end else if (wdog != WD_MAX) begin
          wdog_nxt = wdog + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == BUSY);

  always_comb begin
    s_req   = 1'b0;
    s_cmd   = CMD_READ;
    s_addr  = '0;
    s_wdata = '0;
    if (busy) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (gnt[i]) begin
          s_req   = m_req[i];
          s_cmd   = m_cmd[i];
          s_addr  = m_addr[ADDR_W*i +: ADDR_W];
          s_wdata = m_wdata[DATA_W*i +: DATA_W];
        end
      end
    end
  end

  assign m_ack   = gnt & {NUM_MASTERS{s_ack & busy}};
  assign m_rdata = s_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int NM = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NM-1:0] m_req, m_cmd;
  logic [NM*32-1:0] m_addr, m_wdata;
  logic [NM-1:0] m_ack;
  logic [31:0]   m_rdata;
  logic          s_req, s_cmd;
  logic [31:0]   s_addr, s_wdata;
  logic          s_ack;
  logic [31:0]   s_rdata;
  logic [NM-1:0] gnt;
  logic          busy, timeout_err;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  bus_arbiter #(.NUM_MASTERS(NM), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata),
    .gnt(gnt), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!busy && n < budget);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
    s_ack = 1'b0; s_rdata = '0;
    step(); step();
    total_cnt++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got=%b want=0000", gnt); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else pass_cnt++;
    total_cnt++; if (s_req !== 1'b0 || s_addr !== 32'h0) $display("FAIL reset_s got req=%b addr=%h want 0", s_req, s_addr); else pass_cnt++;
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL reset_terr got=%b want=0", timeout_err); else pass_cnt++;
    rst_n = 1'b1;
    step();
    s_ack = 1'b1;
    #1;
    total_cnt++; if (m_ack !== 4'b0000) $display("FAIL idle_ack_ignored got=%b want=0000", m_ack); else pass_cnt++;
    s_ack = 1'b0;
    step();
    total_cnt++; if (busy !== 1'b0) $display("FAIL idle_no_req_busy got=%b want=0", busy); else pass_cnt++;
  endtask

  task automatic test_single_read();
    m_cmd = 4'b0000;
    m_addr[95:64] = 32'h0000_0040;
    m_req = 4'b0100;
    step();
    total_cnt++; if (gnt !== 4'b0100) $display("FAIL read_gnt got=%b want=0100", gnt); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1 || s_req !== 1'b1) $display("FAIL read_busy_sreq got=%b%b want=11", busy, s_req); else pass_cnt++;
    total_cnt++; if (s_addr !== 32'h40 || s_cmd !== 1'b0) $display("FAIL read_s_addr got=%h cmd=%b want=00000040 cmd=0", s_addr, s_cmd); else pass_cnt++;
    step(); step(); step();
    s_ack = 1'b1; s_rdata = 32'hDEAD_BEEF;
    #1;
    total_cnt++; if (m_ack !== 4'b0100) $display("FAIL read_m_ack got=%b want=0100", m_ack); else pass_cnt++;
    total_cnt++; if (m_rdata !== 32'hDEAD_BEEF) $display("FAIL read_m_rdata got=%h want=deadbeef", m_rdata); else pass_cnt++;
    step();
    s_ack = 1'b0; m_req = 4'b0000;
    total_cnt++; if (busy !== 1'b0 || gnt !== 4'b0000) $display("FAIL read_release got busy=%b gnt=%b want 0/0000", busy, gnt); else pass_cnt++;
    total_cnt++; if (s_req !== 1'b0 || s_addr !== 32'h0) $display("FAIL read_idle_s got req=%b addr=%h want 0", s_req, s_addr); else pass_cnt++;
    step();
  endtask

  task automatic test_round_robin();
    logic [3:0] e;
    int prev;
    do_reset();
    m_req = 4'b1111;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << (k % 4);
      wait_grant(8);
      total_cnt++; if (gnt !== e) $display("FAIL rr_gnt%0d got=%b want=%b", k, gnt, e); else pass_cnt++;
      if (k > 0) begin
        total_cnt++; if (cyc - prev != 3) $display("FAIL rr_spacing%0d got=%0d want=3", k, cyc - prev); else pass_cnt++;
      end
      prev = cyc;
      step();
      s_ack = 1'b1;
      #1;
      total_cnt++; if (m_ack !== e) $display("FAIL rr_ack%0d got=%b want=%b", k, m_ack, e); else pass_cnt++;
      step();
      s_ack = 1'b0;
    end
    m_req = 4'b0000;
    step();
  endtask

  task automatic test_timeout();
    int n;
    int ack_seen;
    m_cmd = 4'b0010;
    m_addr[63:32] = 32'h0000_0100;
    m_wdata[63:32] = 32'h0000_CAFE;
    m_req = 4'b0010;
    wait_grant(4);
    total_cnt++; if (gnt !== 4'b0010) $display("FAIL to_gnt got=%b want=0010", gnt); else pass_cnt++;
    total_cnt++; if (s_cmd !== 1'b1 || s_wdata !== 32'hCAFE) $display("FAIL to_s_fields got cmd=%b wdata=%h want 1/0000cafe", s_cmd, s_wdata); else pass_cnt++;
    n = 1; ack_seen = 0;
    while (busy && n < 40) begin
      step();
      if (m_ack !== 4'b0000) ack_seen = 1;
      if (busy) n++;
    end
    total_cnt++; if (n != 16) $display("FAIL to_busy_cycles got=%0d want=16", n); else pass_cnt++;
    total_cnt++; if (timeout_err !== 1'b1) $display("FAIL to_err_pulse got=%b want=1", timeout_err); else pass_cnt++;
    total_cnt++; if (s_req !== 1'b0) $display("FAIL to_s_req got=%b want=0", s_req); else pass_cnt++;
    total_cnt++; if (ack_seen != 0) $display("FAIL to_no_ack got=%0d want=0", ack_seen); else pass_cnt++;
    m_req = 4'b0000;
    step();
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL to_err_single got=%b want=0", timeout_err); else pass_cnt++;
  endtask

  task automatic test_collision();
    m_req = 4'b0010;
    wait_grant(4);
    for (int i = 1; i < 16; i++) step();
    total_cnt++; if (busy !== 1'b1) $display("FAIL col_busy16 got=%b want=1", busy); else pass_cnt++;
    s_ack = 1'b1; s_rdata = 32'h1234_5678;
    #1;
    total_cnt++; if (m_ack !== 4'b0010) $display("FAIL col_m_ack got=%b want=0010", m_ack); else pass_cnt++;
    step();
    s_ack = 1'b0; m_req = 4'b0000;
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL col_no_err got=%b want=0", timeout_err); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL col_release got=%b want=0", busy); else pass_cnt++;
    step();
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL col_no_err_late got=%b want=0", timeout_err); else pass_cnt++;
  endtask

  task automatic test_abort_reset();
    m_req = 4'b1000;
    wait_grant(4);
    total_cnt++; if (gnt !== 4'b1000) $display("FAIL ab_gnt got=%b want=1000", gnt); else pass_cnt++;
    m_req = 4'b0000;
    #1;
    total_cnt++; if (s_req !== 1'b0 || m_ack !== 4'b0000) $display("FAIL ab_drop got s_req=%b m_ack=%b want 0/0000", s_req, m_ack); else pass_cnt++;
    step();
    total_cnt++; if (busy !== 1'b0 || gnt !== 4'b0000) $display("FAIL ab_release got busy=%b gnt=%b want 0/0000", busy, gnt); else pass_cnt++;
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL ab_no_err got=%b want=0", timeout_err); else pass_cnt++;
    m_cmd = 4'b0100;
    m_addr[95:64] = 32'h0000_0080;
    m_wdata[95:64] = 32'h0000_00AA;
    m_req = 4'b0100;
    wait_grant(4);
    total_cnt++; if (gnt !== 4'b0100) $display("FAIL rst_pre_gnt got=%b want=0100", gnt); else pass_cnt++;
    rst_n = 1'b0;
    m_req = 4'b0101;
    m_cmd = 4'b0000;
    step();
    total_cnt++; if (gnt !== 4'b0000 || busy !== 1'b0) $display("FAIL rst_mid_gnt got gnt=%b busy=%b want 0000/0", gnt, busy); else pass_cnt++;
    total_cnt++; if (s_req !== 1'b0 || s_cmd !== 1'b0 || s_addr !== 32'h0 || s_wdata !== 32'h0)
      $display("FAIL rst_mid_s got req=%b cmd=%b addr=%h wdata=%h want 0", s_req, s_cmd, s_addr, s_wdata); else pass_cnt++;
    total_cnt++; if (timeout_err !== 1'b0 || m_ack !== 4'b0000) $display("FAIL rst_mid_err got terr=%b m_ack=%b want 0", timeout_err, m_ack); else pass_cnt++;
    rst_n = 1'b1;
    step();
    total_cnt++; if (gnt !== 4'b0001) $display("FAIL rst_first_gnt got=%b want=0001", gnt); else pass_cnt++;
    m_req = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_collision();
    test_abort_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=stuck want=finish");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares one slave port of the req/cmd/addr/wdata/ack/rdata bus among `NUM_MASTERS` bus masters. Each master keeps its request and command fields stable until it sees a single-cycle `ack`. The arbiter grants one master at a time, muxes that master's command onto the slave side and returns `ack` only to the granted master. A per-transfer watchdog releases the bus if the slave never acknowledges. It sits between the master functional models (or real masters) and the shared slave.

## Interface
- `NUM_MASTERS`, 4: number of requesters, 2..8.
- `TIMEOUT`, 16: cycles in BUSY without `s_ack` before forced release, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `m_req`  in  NUM_MASTERS  per-master request, held until acked.
- `m_cmd`  in  NUM_MASTERS  per-master command, 1 = write, 0 = read.
- `m_addr`  in  NUM_MASTERS*32  packed addresses; master i occupies [32i+31:32i].
- `m_wdata`  in  NUM_MASTERS*32  packed write data, same packing.
- `m_ack`  out  NUM_MASTERS  per-master acknowledge pulse.
- `m_rdata`  out  32  read data, broadcast; valid when that master's `m_ack` is high.
- `s_req`  out  1  request to the slave.
- `s_cmd`  out  1  command to the slave.
- `s_addr`  out  32  address to the slave.
- `s_wdata`  out  32  write data to the slave.
- `s_ack`  in  1  slave acknowledge, single-cycle pulse.
- `s_rdata`  in  32  slave read data.
- `gnt`  out  NUM_MASTERS  one-hot current grant; zero when idle.
- `busy`  out  1  arbiter in BUSY.
- `timeout_err`  out  1  one-cycle pulse on watchdog release.

## Operation
- **States.**
  - IDLE: no grant.
  - BUSY: one master granted.
- **IDLE → BUSY.** If any `m_req` bit is set, pick the first set bit searching upward from `last_gnt+1`, wrapping modulo `NUM_MASTERS`. Register it into `gnt` and `last_gnt`, clear the watchdog, and enter BUSY.
- **BUSY → IDLE** on the first of the following:
  - (a) `s_ack` = 1;
  - (b) the granted master drops `m_req` (abort), with no ack issued;
  - (c) the watchdog reaches `TIMEOUT-1` with `s_ack` = 0. `timeout_err` pulses on the next cycle.
- **Simultaneous events.** If `s_ack` and the timeout occur in the same cycle, the ack wins and there is no error.
- **Re-grant.** Every transfer returns to IDLE for at least one cycle. This guarantees the acked master's `req` has fallen before re-arbitration.
- **Slave-side outputs.** In BUSY, `s_req = m_req[g]` and `s_cmd/s_addr/s_wdata` are the granted master's fields (combinational mux from registered `gnt`). In IDLE, all four are 0.
- **Acknowledge routing.** `m_ack[i] = s_ack & gnt[i] & busy`. An `s_ack` in IDLE is ignored. `m_rdata = s_rdata` always.
- **Watchdog.** `$clog2(TIMEOUT)`-bit counter. Increments every BUSY cycle, saturates, and clears on entry to BUSY.
- **Reset** (`rst_n` = 0 at a clock edge):
  - state = IDLE, `gnt` = 0, `busy` = 0, `timeout_err` = 0, watchdog = 0;
  - `last_gnt = NUM_MASTERS-1`, so master 0 is served first;
  - `s_req/s_cmd/s_addr/s_wdata` = 0, `m_ack` = 0.
  - Reset mid-transfer drops the grant with no ack and no error pulse.

## Timing
- **Request to slave.** `m_req[i]` rising before edge N gives `gnt`/`busy` and `s_req` high in cycle N (after edge N). Latency is 1 clock.
- **Ack return.** `s_ack` in cycle K gives `m_ack[i]` in cycle K (combinational). State is IDLE from edge K+1.
- **Next grant.** The earliest next grant is at edge K+2. Back-to-back throughput is one transfer per 3 cycles when the slave acks immediately.
- **Timeout.** Release happens at edge N+TIMEOUT. `timeout_err` is high for exactly cycle N+TIMEOUT.
- **Combinational paths.** `gnt`, `busy` and `timeout_err` are registered outputs. `m_ack`, `m_rdata` and the `s_*` command outputs have combinational paths from `s_ack`/`s_rdata`/`m_*`.

## Structure
- **Package `bus_pkg`** holds:
  - `ADDR_W` = 32 and `DATA_W` = 32;
  - `CMD_READ` = 1'b0 and `CMD_WRITE` = 1'b1;
  - the `arb_state_t` enum {IDLE, BUSY}.
- **Sub-module `rr_picker`** (combinational) takes the request vector and the `last_gnt` pointer and outputs a one-hot next grant plus a valid flag. It is reused by future arbiters.
- **Top level** holds the FSM, watchdog, grant register, output mux and ack demux.

## Test plan
- **Single read.** Reset, then master 2 requests a read (`m_cmd` = 0) at addr 0x0000_0040. Required: `gnt` = 4'b0100 one cycle later and `s_addr` = 0x40. The slave acks after 3 cycles with `s_rdata` = 0xDEAD_BEEF, giving `m_ack[2]` = 1 and `m_rdata` = 0xDEAD_BEEF. No other `m_ack` bit is set.
- **Round robin.** All 4 masters hold `req` and the slave acks every transfer immediately. Required: grant order 0,1,2,3,0, with successive grants 3 cycles apart.
- **Timeout.** Master 1 writes and the slave never acks. Required: `s_req` falls after 16 BUSY cycles, `timeout_err` pulses once, and `m_ack` stays 0.
- **Ack/timeout collision.** `s_ack` arrives on cycle 16 of BUSY. Required: `m_ack[1]` = 1 and `timeout_err` = 0.
- **Abort and reset.** Master 3 drops `req` mid-transfer, then IDLE follows with no ack. Separately, asserting `rst_n` = 0 during BUSY gives `gnt` = 0 and all `s_*` = 0 on the next edge. Master 0 is granted first after release.
